// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the reaction-timer display path: phase encoding,
//   the blank segment byte and the 48-bit packing of the six digits.
//   Packing order: [47:40] -> HEX5, ..., [7:0] -> HEX0.
//   The banner scroller and result formatter import this package as well.
package display_pkg;

   typedef enum logic [1:0] {
      PH_BANNER = 2'b00,
      PH_ARMED  = 2'b01,
      PH_RESULT = 2'b10
   } phase_t;

   localparam int          NUM_DIGITS = 6;
   localparam int          HEX_W      = 8 * NUM_DIGITS;
   localparam logic [7:0]  BLANK_HEX  = 8'hFF;
   localparam logic [47:0] BLANK_ALL  = {NUM_DIGITS{BLANK_HEX}};

   // Extract digit idx (0 = HEX0) from a packed 48-bit segment word.
   function automatic logic [7:0] digit_of(input logic [47:0] packed_hex,
                                           input int idx);
      return packed_hex[idx*8 +: 8];
   endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// display_scheduler_if
//   Groups the scheduler's source-side and status signals.
//   start_req, result_valid, result_hex, banner_hex : driven by the control side
//   scroll_tick, busy, phase                        : driven by the scheduler
//
// Handshake: there is no ready. start_req and result_valid are single-cycle
// pulses that the scheduler samples on every rising edge; a pulse is either
// acted on in that cycle or ignored for good (e.g. result_valid outside
// ARMED), it is never held pending. result_hex only needs to be valid in the
// cycle result_valid is high.
interface display_scheduler_if;
   import display_pkg::*;

   logic                start_req;
   logic                result_valid;
   logic [HEX_W-1:0]    result_hex;
   logic [HEX_W-1:0]    banner_hex;
   logic                scroll_tick;
   logic                busy;
   logic [1:0]          phase;

   modport master (
      output start_req, result_valid, result_hex, banner_hex,
      input  scroll_tick, busy, phase
   );

   modport slave (
      input  start_req, result_valid, result_hex, banner_hex,
      output scroll_tick, busy, phase
   );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Free-running divider producing a one-cycle tick every TICK_DIV clocks.
//   Ports: clock, reset (sync, active-high), tick (high when count==TICK_DIV-1).
//   The count wraps to 0 in the same cycle tick is high.
module tick_prescaler #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int          W    = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler
//   Chooses what the six seven-segment displays show across a reaction-timer
//   run: scrolling banner when idle, blank while armed, held result after.
//   Ports:
//     clock, reset       system clock, synchronous active-high reset
//     bus (slave)        start_req / result_valid / result_hex / banner_hex in,
//                        scroll_tick / busy / phase out (phase is the FSM state)
//     HEX0..HEX5         registered active-low segment bytes (8'hFF = off)
module display_scheduler
   import display_pkg::*;
#(
   parameter int TICK_DIV    = 25_000_000,
   parameter int HOLD_TICKS  = 6,
   parameter int ARM_TIMEOUT = 20
) (
   input  logic                 clock,
   input  logic                 reset,
   display_scheduler_if.slave   bus,
   output logic [7:0]           HEX0,
   output logic [7:0]           HEX1,
   output logic [7:0]           HEX2,
   output logic [7:0]           HEX3,
   output logic [7:0]           HEX4,
   output logic [7:0]           HEX5
);

   localparam int MAX_TICKS = (HOLD_TICKS > ARM_TIMEOUT) ? HOLD_TICKS : ARM_TIMEOUT;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
   localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT - 1);

   logic                tick;
   phase_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [HEX_W-1:0]    latched, latched_nxt;
   logic [HEX_W-1:0]    hex_q, hex_nxt;

   // Free-running: never cleared on phase changes, so the first tick counted
   // in ARMED/RESULT may arrive after less than a full tick period.
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= PH_BANNER;
         cnt     <= '0;
         latched <= BLANK_ALL;
         hex_q   <= BLANK_ALL;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         latched <= latched_nxt;
         hex_q   <= hex_nxt;
      end
   end

   // Next phase / tick count / latched result.
   // Within a cycle: result_valid (ARMED) beats start_req beats tick expiry.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      latched_nxt = latched;
      case (state)
         PH_BANNER: begin
            cnt_nxt = '0;
            if (bus.start_req) begin
               state_nxt = PH_ARMED;
            end
         end
         PH_ARMED: begin
            if (bus.result_valid) begin
               state_nxt   = PH_RESULT;
               cnt_nxt     = '0;
               latched_nxt = bus.result_hex;
            end else if (tick) begin
               if (cnt == ARM_LAST) begin
                  state_nxt = PH_BANNER;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         PH_RESULT: begin
            if (bus.start_req) begin
               state_nxt = PH_ARMED;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (cnt == HOLD_LAST) begin
                  state_nxt = PH_BANNER;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            // Unused encoding 2'b11: recover to the banner.
            state_nxt = PH_BANNER;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output mux is driven from the registered phase, so pins lag a phase
   // change by one cycle (first ARMED cycle still shows the banner).
   always_comb begin
      hex_nxt = BLANK_ALL;
      case (state)
         PH_BANNER: hex_nxt = bus.banner_hex;
         PH_ARMED:  hex_nxt = BLANK_ALL;
         PH_RESULT: hex_nxt = latched;
         default:   hex_nxt = BLANK_ALL;
      endcase
   end

   assign bus.phase       = state;
   assign bus.scroll_tick = (state == PH_BANNER) && tick;
   assign bus.busy        = (state == PH_ARMED) || (state == PH_RESULT);

   assign HEX0 = digit_of(hex_q, 0);
   assign HEX1 = digit_of(hex_q, 1);
   assign HEX2 = digit_of(hex_q, 2);
   assign HEX3 = digit_of(hex_q, 3);
   assign HEX4 = digit_of(hex_q, 4);
   assign HEX5 = digit_of(hex_q, 5);

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//   Self-checking bench for display_scheduler with TICK_DIV=4, HOLD_TICKS=2,
//   ARM_TIMEOUT=3. A behavioural model tracks cycles since reset, ticks seen
//   in the current phase and the expected pins; outputs are compared every
//   cycle, #1 after the rising edge.
module tb_display_scheduler;

   localparam int TD   = 4;
   localparam int HOLD = 2;
   localparam int ARMT = 3;
   localparam logic [47:0] ALL_FF = 48'hFFFF_FFFF_FFFF;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

   display_scheduler_if bus ();

   display_scheduler #(
      .TICK_DIV    (TD),
      .HOLD_TICKS  (HOLD),
      .ARM_TIMEOUT (ARMT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .HEX0  (hex0),
      .HEX1  (hex1),
      .HEX2  (hex2),
      .HEX3  (hex3),
      .HEX4  (hex4),
      .HEX5  (hex5)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   int          checks = 0;
   int          errors = 0;
   int          m_phase;        // 0 banner, 1 armed, 2 result
   int          m_since;        // cycles since prescaler reset, modulo TD
   int          m_ticks;        // ticks seen in the current armed/result phase
   logic [47:0] m_latch;
   logic [47:0] m_hex;

   function automatic logic [47:0] pins();
      return {hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply the rules for one rising edge, using the inputs currently driven.
   task automatic model_edge();
      bit          tick;
      logic [47:0] shown;
      tick  = (m_since == TD - 1);
      shown = (m_phase == 0) ? bus.banner_hex : (m_phase == 1) ? ALL_FF : m_latch;
      if (reset) begin
         m_phase = 0; m_since = 0; m_ticks = 0; m_latch = ALL_FF; m_hex = ALL_FF;
      end else begin
         m_hex = shown;
         if (m_phase == 0) begin
            if (bus.start_req) begin m_phase = 1; m_ticks = 0; end
         end else if (m_phase == 1) begin
            if (bus.result_valid) begin
               m_phase = 2; m_ticks = 0; m_latch = bus.result_hex;
            end else if (tick) begin
               m_ticks++;
               if (m_ticks == ARMT) begin m_phase = 0; m_ticks = 0; end
            end
         end else begin
            if (bus.start_req) begin
               m_phase = 1; m_ticks = 0;
            end else if (tick) begin
               m_ticks++;
               if (m_ticks == HOLD) begin m_phase = 0; m_ticks = 0; end
            end
         end
         m_since = (m_since + 1) % TD;
      end
   endtask

   task automatic advance();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic check_outputs();
      chk("phase", {46'd0, bus.phase}, 48'(m_phase));
      chk("busy", {47'd0, bus.busy}, {47'd0, (m_phase != 0)});
      chk("scroll_tick", {47'd0, bus.scroll_tick}, {47'd0, (m_phase == 0 && m_since == TD - 1)});
      chk("hex", pins(), m_hex);
   endtask

   task automatic cycle();
      check_outputs();
      advance();
   endtask

   task automatic drive(input bit sr, input bit rv, input logic [47:0] rh);
      bus.start_req    = sr;
      bus.result_valid = rv;
      bus.result_hex   = rh;
   endtask

   task automatic new_banner();
      bus.banner_hex = {$urandom, 16'($urandom)};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      drive(0, 0, '0);
      bus.banner_hex = 48'h123456789ABC;
      m_phase = 0; m_since = 0; m_ticks = 0; m_latch = ALL_FF; m_hex = ALL_FF;

      // Reset held 3 cycles.
      advance();
      repeat (2) cycle();
      check_outputs();
      reset = 1'b0;

      // Banner scrolling: scroll_tick every 4th cycle, HEX follows banner.
      for (int i = 0; i < 10; i++) begin new_banner(); cycle(); end

      // Both pulses in BANNER: goes ARMED, result ignored.
      drive(1, 1, 48'h111111111111);
      cycle();
      drive(0, 0, '0);
      chk("armed_after_start", {46'd0, bus.phase}, 48'd1);
      cycle();
      chk("armed_blank", pins(), ALL_FF);

      // Result while ARMED.
      drive(0, 1, 48'hC0F9A4B09992);
      cycle();
      drive(0, 0, '0);
      chk("result_phase", {46'd0, bus.phase}, 48'd2);
      cycle();
      chk("result_pins", pins(), 48'hC0F9A4B09992);
      for (int i = 0; i < 12; i++) begin new_banner(); cycle(); end

      // ARMED with no result: timeout back to banner.
      drive(1, 0, '0);
      cycle();
      drive(0, 0, '0);
      for (int i = 0; i < 16; i++) begin new_banner(); cycle(); end
      chk("timeout_back_to_banner", {46'd0, bus.phase}, 48'd0);

      // Both pulses in ARMED: result wins.
      drive(1, 0, '0);
      cycle();
      drive(1, 1, 48'hA4A4A4A4A4A4);
      cycle();
      drive(0, 0, '0);
      chk("both_in_armed", {46'd0, bus.phase}, 48'd2);
      cycle();

      // Reset pulse while in RESULT, then a normal start.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("reset_mid_phase", {46'd0, bus.phase}, 48'd0);
      chk("reset_mid_hex", pins(), ALL_FF);
      chk("reset_mid_busy", {47'd0, bus.busy}, 48'd0);
      drive(1, 0, '0);
      cycle();
      drive(0, 0, '0);
      chk("start_after_reset", {46'd0, bus.phase}, 48'd1);

      // Randomized run.
      for (int i = 0; i < 600; i++) begin
         new_banner();
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
               {$urandom, 16'($urandom)});
         reset = ($urandom_range(0, 149) == 0);
         cycle();
      end
      reset = 1'b0;
      drive(0, 0, '0);
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: the run is a fixed-length sequence, this only guards a hang.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
